// File: rtl/bsg_cache_nb_pkg.sv
// Shared types, width macros and helpers for the bsg_cache_nb DMA concentrator.
`define BSG_CACHE_NB_DMA_PKT_WIDTH(addr_mp, mshr_mp) (1 + (addr_mp) + (mshr_mp))

`define BSG_CACHE_NB_MEM_PKT_WIDTH(addr_mp, blk_mp, mshr_mp, ncache_mp) \
  (`BSG_CACHE_NB_DMA_PKT_WIDTH(addr_mp, mshr_mp) + (((ncache_mp) == 1) ? 0 : $clog2(ncache_mp)))

`define DECLARE_BSG_CACHE_NB_DMA_PKT_S(addr_mp, mshr_mp) \
  typedef struct packed { \
    logic                   write_not_read; \
    logic [(addr_mp)-1:0]   addr; \
    logic [(mshr_mp)-1:0]   mshr_id; \
  } bsg_cache_nb_dma_pkt_s

package bsg_cache_nb_pkg;

  typedef enum logic {
    eWrIdle = 1'b0,
    eWrBusy = 1'b1
  } wr_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Combinational round-robin pick starting at an internal pointer; the pointer
// advances past the winner only when the grant is consumed.
module bsg_arb_round_robin
  import bsg_cache_nb_pkg::*;
#(
  parameter int width_p = 2,
  localparam int tag_w_lp = safe_clog2(width_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [width_p-1:0]  reqs_i,
  output logic [width_p-1:0]  grants_o,
  output logic                v_o,
  output logic [tag_w_lp-1:0] tag_o,
  input  logic                yumi_i
);

  logic [tag_w_lp-1:0] ptr_q, ptr_d;

  // Scan from farthest to nearest so the request closest to the pointer wins.
  always_comb begin
    int idx;
    idx      = 0;
    v_o      = 1'b0;
    tag_o    = '0;
    grants_o = '0;
    for (int k = width_p - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % width_p;
      if (reqs_i[tag_w_lp'(idx)]) begin
        v_o   = 1'b1;
        tag_o = tag_w_lp'(idx);
      end
    end
    if (v_o) grants_o[tag_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (v_o && yumi_i)
      ptr_d = (int'(tag_o) == width_p - 1) ? '0 : tag_o + tag_w_lp'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bsg_cache_nb_dma_mux_wr_ctrl.sv
// Write-burst ownership: who owns the evict stream and how many beats remain.
module bsg_cache_nb_dma_mux_wr_ctrl
  import bsg_cache_nb_pkg::*;
#(
  parameter int num_cache_p = 2,
  parameter int bursts_p    = 4,
  localparam int tag_w_lp = safe_clog2(num_cache_p),
  localparam int cnt_w_lp = safe_clog2(bursts_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [tag_w_lp-1:0] owner_i,
  input  logic                beat_i,
  output logic                busy_o,
  output logic [tag_w_lp-1:0] owner_o
);

  localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(bursts_p - 1);

  wr_state_e           state_q, state_d;
  logic [tag_w_lp-1:0] owner_q, owner_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      eWrIdle: begin
        if (start_i) begin
          state_d = eWrBusy;
          owner_d = owner_i;
          cnt_d   = '0;
        end
      end
      eWrBusy: begin
        if (beat_i) begin
          if (cnt_q == last_beat_lp) begin
            cnt_d   = '0;
            state_d = eWrIdle;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end
      end
      default: state_d = eWrIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eWrIdle;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o  = (state_q == eWrBusy);
  assign owner_o = owner_q;

endmodule

// File: rtl/bsg_cache_nb_dma_mux.sv
// Concentrates N caches' DMA packets/evict beats onto one memory channel and
// steers tagged refill beats back to the owning cache.
module bsg_cache_nb_dma_mux
  import bsg_cache_nb_pkg::*;
#(
  parameter int num_cache_p           = 2,
  parameter int addr_width_p          = 32,
  parameter int word_width_p          = 32,
  parameter int block_size_in_words_p = 16,
  parameter int dma_data_width_p      = 128,
  parameter int mshr_els_p            = 4,
  localparam int lg_mshr_lp  = safe_clog2(mshr_els_p),
  localparam int lg_cache_lp = (num_cache_p == 1) ? 0 : $clog2(num_cache_p),
  localparam int pkt_w_lp    = `BSG_CACHE_NB_DMA_PKT_WIDTH(addr_width_p, lg_mshr_lp),
  localparam int mem_pkt_w_lp =
    `BSG_CACHE_NB_MEM_PKT_WIDTH(addr_width_p, block_size_in_words_p, lg_mshr_lp, num_cache_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_cache_p*pkt_w_lp-1:0]       dma_pkt_i,
  input  logic [num_cache_p-1:0]                dma_pkt_v_i,
  output logic [num_cache_p-1:0]                dma_pkt_yumi_o,
  input  logic [num_cache_p*dma_data_width_p-1:0] dma_data_i,
  input  logic [num_cache_p-1:0]                dma_data_v_i,
  output logic [num_cache_p-1:0]                dma_data_yumi_o,
  output logic [dma_data_width_p-1:0]           dma_data_o,
  output logic [lg_mshr_lp-1:0]                 dma_mshr_id_o,
  output logic [num_cache_p-1:0]                dma_data_v_o,
  input  logic [num_cache_p-1:0]                dma_data_ready_i,
  output logic [mem_pkt_w_lp-1:0]               mem_pkt_o,
  output logic                                  mem_pkt_v_o,
  input  logic                                  mem_pkt_yumi_i,
  output logic [dma_data_width_p-1:0]           mem_wdata_o,
  output logic                                  mem_wdata_v_o,
  input  logic                                  mem_wdata_yumi_i,
  input  logic [dma_data_width_p-1:0]           mem_rdata_i,
  input  logic [lg_cache_lp+lg_mshr_lp-1:0]     mem_rtag_i,
  input  logic                                  mem_rdata_v_i,
  output logic                                  mem_rdata_ready_o
);

  localparam int bursts_lp = block_size_in_words_p * word_width_p / dma_data_width_p;
  localparam int tag_w_lp  = safe_clog2(num_cache_p);

  `DECLARE_BSG_CACHE_NB_DMA_PKT_S(addr_width_p, lg_mshr_lp);

  logic [num_cache_p-1:0][pkt_w_lp-1:0]         pkt_in;
  logic [num_cache_p-1:0][dma_data_width_p-1:0] data_in;
  bsg_cache_nb_dma_pkt_s sel_pkt;

  logic                   live;
  logic                   wr_busy, wr_start, wr_beat;
  logic [tag_w_lp-1:0]    wr_owner, grant_tag;
  logic [num_cache_p-1:0] eligible, grants;
  logic                   grant_v;

  assign pkt_in  = dma_pkt_i;
  assign data_in = dma_data_i;
  assign live    = ~reset_i;

  // Any in-flight evict burst blocks all packets so reads cannot overtake it.
  assign eligible = dma_pkt_v_i & {num_cache_p{~wr_busy}};

  bsg_arb_round_robin #(.width_p(num_cache_p)) arb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .reqs_i   (eligible),
    .grants_o (grants),
    .v_o      (grant_v),
    .tag_o    (grant_tag),
    .yumi_i   (mem_pkt_yumi_i)
  );

  assign sel_pkt     = pkt_in[grant_tag];
  assign mem_pkt_v_o = live & grant_v;
  assign wr_start    = grant_v & mem_pkt_yumi_i & sel_pkt.write_not_read;
  assign wr_beat     = wr_busy & mem_wdata_yumi_i;

  bsg_cache_nb_dma_mux_wr_ctrl #(
    .num_cache_p (num_cache_p),
    .bursts_p    (bursts_lp)
  ) wr_ctrl (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (wr_start),
    .owner_i (grant_tag),
    .beat_i  (wr_beat),
    .busy_o  (wr_busy),
    .owner_o (wr_owner)
  );

  assign mem_wdata_o   = data_in[wr_owner];
  assign mem_wdata_v_o = live & wr_busy & dma_data_v_i[wr_owner];

  always_comb begin
    dma_pkt_yumi_o  = '0;
    dma_data_yumi_o = '0;
    for (int i = 0; i < num_cache_p; i++) begin
      dma_pkt_yumi_o[i]  = live & grants[i] & mem_pkt_yumi_i;
      dma_data_yumi_o[i] = live & wr_beat & (wr_owner == tag_w_lp'(i));
    end
  end

  assign dma_data_o = mem_rdata_i;

  if (num_cache_p == 1) begin : g_single
    assign mem_pkt_o         = sel_pkt;
    assign dma_mshr_id_o     = mem_rtag_i;
    assign dma_data_v_o      = live & mem_rdata_v_i;
    assign mem_rdata_ready_o = dma_data_ready_i[0];
  end else begin : g_multi
    logic [lg_cache_lp-1:0] cid;

    assign cid               = mem_rtag_i[lg_mshr_lp +: lg_cache_lp];
    assign mem_pkt_o         = {grant_tag, sel_pkt};
    assign dma_mshr_id_o     = mem_rtag_i[lg_mshr_lp-1:0];
    assign mem_rdata_ready_o = dma_data_ready_i[cid];

    always_comb begin
      dma_data_v_o = '0;
      for (int i = 0; i < num_cache_p; i++)
        dma_data_v_o[i] = live & mem_rdata_v_i & (cid == lg_cache_lp'(i));
    end

    // Cache ids beyond num_cache_p are only representable for non-power-of-two N.
    if ((1 << lg_cache_lp) != num_cache_p) begin : g_cid_chk
      always @(posedge clk_i) begin
        if (!reset_i && mem_rdata_v_i)
          assert (int'(cid) < num_cache_p);
      end
    end
  end

endmodule

// File: tb/tb_bsg_cache_nb_dma_mux.sv
// Bench for bsg_cache_nb_dma_mux: directed scenarios followed by randomized traffic
// checked every cycle against a transaction-level model.
module tb_bsg_cache_nb_dma_mux;

  localparam int N      = 2;
  localparam int AW     = 32;
  localparam int LGM    = 2;
  localparam int DW     = 128;
  localparam int PKT_W  = 1 + AW + LGM;
  localparam int BURSTS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0][PKT_W-1:0] pkt_a;
  logic [N-1:0]            pkt_v, pkt_yumi;
  logic [N-1:0][DW-1:0]    ev_data;
  logic [N-1:0]            ev_v, ev_yumi;
  logic [DW-1:0]           rf_data;
  logic [LGM-1:0]          rf_mshr;
  logic [N-1:0]            rf_v, rf_ready;
  logic [PKT_W:0]          mem_pkt;
  logic                    mem_pkt_v, mem_pkt_yumi;
  logic [DW-1:0]           wdata;
  logic                    wdata_v, wdata_yumi;
  logic [DW-1:0]           rdata;
  logic [2:0]              rtag;
  logic                    rdata_v, rdata_ready;

  bsg_cache_nb_dma_mux #(
    .num_cache_p(N), .addr_width_p(AW), .word_width_p(32),
    .block_size_in_words_p(16), .dma_data_width_p(DW), .mshr_els_p(4)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .dma_pkt_i(pkt_a), .dma_pkt_v_i(pkt_v), .dma_pkt_yumi_o(pkt_yumi),
    .dma_data_i(ev_data), .dma_data_v_i(ev_v), .dma_data_yumi_o(ev_yumi),
    .dma_data_o(rf_data), .dma_mshr_id_o(rf_mshr), .dma_data_v_o(rf_v),
    .dma_data_ready_i(rf_ready),
    .mem_pkt_o(mem_pkt), .mem_pkt_v_o(mem_pkt_v), .mem_pkt_yumi_i(mem_pkt_yumi),
    .mem_wdata_o(wdata), .mem_wdata_v_o(wdata_v), .mem_wdata_yumi_i(wdata_yumi),
    .mem_rdata_i(rdata), .mem_rtag_i(rtag), .mem_rdata_v_i(rdata_v),
    .mem_rdata_ready_o(rdata_ready)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Transaction-level model: next cache in turn, and beats still owed by the evicting cache.
  int   m_ptr;
  bit   m_busy;
  logic m_owner;
  int   m_left;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk(input logic wr, input logic [AW-1:0] addr,
                                          input logic [LGM-1:0] mshr);
    return {wr, addr, mshr};
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pick();
    if (m_busy || rst) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (pkt_v[idx[0]]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr   <= 0;
      m_busy  <= 1'b0;
      m_owner <= 1'b0;
      m_left  <= 0;
    end else if (!m_busy) begin
      if (pick() >= 0 && mem_pkt_yumi) begin
        m_ptr <= (pick() + 1) % N;
        if (pkt_a[1'(pick())][PKT_W-1]) begin
          m_busy  <= 1'b1;
          m_owner <= 1'(pick());
          m_left  <= BURSTS;
        end
      end
    end else if (wdata_yumi) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_busy <= 1'b0;
    end
  end

  task automatic compare_all();
    int g;
    logic [N-1:0] exp_v;
    g = pick();
    check("pkt_v", mem_pkt_v, g >= 0);
    if (g >= 0) check("mem_pkt", mem_pkt, {1'(g), pkt_a[1'(g)]});
    exp_v = (g >= 0 && mem_pkt_yumi) ? (2'b01 << g) : 2'b00;
    check("pkt_yumi", pkt_yumi, exp_v);
    check("wdata_v", wdata_v, m_busy && ev_v[m_owner]);
    if (m_busy) check("wdata", wdata, ev_data[m_owner]);
    exp_v = (m_busy && wdata_yumi) ? (2'b01 << m_owner) : 2'b00;
    check("ev_yumi", ev_yumi, exp_v);
    exp_v = rdata_v ? (2'b01 << rtag[2]) : 2'b00;
    check("rf_v", rf_v, exp_v);
    check("rf_ready", rdata_ready, rf_ready[rtag[2]]);
    check("rf_mshr", rf_mshr, rtag[1:0]);
    check("rf_data", rf_data, rdata);
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en && !rst) compare_all();
  end

  task automatic idle();
    pkt_a = '0; pkt_v = '0; ev_data = '0; ev_v = '0; rf_ready = '0;
    mem_pkt_yumi = 1'b0; wdata_yumi = 1'b0;
    rdata = '0; rtag = '0; rdata_v = 1'b0;
  endtask

  logic [1:0] alt_exp [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    idle();
    rst = 1'b1;
    // Reset with every request active: valids and yumis must still read 0.
    pkt_v = 2'b11; ev_v = 2'b11; mem_pkt_yumi = 1'b1; wdata_yumi = 1'b1;
    rdata_v = 1'b1; rtag = 3'b100;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pkt_v", mem_pkt_v, 1'b0);
    check("rst_wdata_v", wdata_v, 1'b0);
    check("rst_pkt_yumi", pkt_yumi, 2'b00);
    check("rst_ev_yumi", ev_yumi, 2'b00);
    check("rst_rf_v", rf_v, 2'b00);

    // Cache0 read, mshr 2 at 0x1000, granted in the same cycle.
    @(negedge clk);
    idle(); rst = 1'b0;
    pkt_a[0] = mk(1'b0, 32'h1000, 2'd2); pkt_v = 2'b01; mem_pkt_yumi = 1'b1;
    #1;
    check("t1_pkt_v", mem_pkt_v, 1'b1);
    check("t1_mem_pkt", mem_pkt, 36'h0_0000_4002);
    check("t1_pkt_yumi", pkt_yumi, 2'b01);

    // Both caches read continuously; pointer moved to 1 so grants run 1,0,1,0.
    pkt_a[1] = mk(1'b0, 32'h2000, 2'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pkt_v = 2'b11; ev_v = 2'b11; wdata_yumi = 1'b1;
      #1;
      check("t2_alt", pkt_yumi, alt_exp[i]);
      check("t2_no_evict", ev_yumi, 2'b00);
    end

    // Cache1 evicts 4 beats while cache0 read waits; a cache0 refill runs alongside.
    @(negedge clk);
    wdata_yumi = 1'b0; ev_v = 2'b00;
    pkt_a[1] = mk(1'b1, 32'h3000, 2'd0); pkt_v = 2'b10;
    #1;
    check("t3_wr_grant", pkt_yumi, 2'b10);
    for (int b = 0; b < BURSTS; b++) begin
      @(negedge clk);
      pkt_v = 2'b01; ev_v = 2'b11; ev_data[1] = rnd128(); ev_data[0] = rnd128();
      wdata_yumi = 1'b1;
      rdata_v = (b < 2); rtag = 3'b001; rf_ready = 2'b01; rdata = rnd128();
      #1;
      check("t3_read_held", mem_pkt_v, 1'b0);
      check("t3_ev_yumi", ev_yumi, 2'b10);
      check("t3_wdata", wdata, ev_data[1]);
      check("t5_rf_v", rf_v, (b < 2) ? 2'b01 : 2'b00);
    end
    @(negedge clk);
    wdata_yumi = 1'b0; rdata_v = 1'b0;
    #1;
    check("t3_read_released", pkt_yumi, 2'b01);
    check("t3_not_busy", wdata_v, 1'b0);

    // Refill to cache1 mshr 3 stalls until cache1 is ready.
    @(negedge clk);
    pkt_v = 2'b00; ev_v = 2'b00; mem_pkt_yumi = 1'b0;
    rdata_v = 1'b1; rtag = 3'b111; rf_ready = 2'b01;
    #1;
    check("t4_rf_v", rf_v, 2'b10);
    check("t4_not_ready", rdata_ready, 1'b0);
    check("t4_mshr", rf_mshr, 2'd3);
    @(negedge clk);
    rf_ready = 2'b11;
    #1;
    check("t4_ready", rdata_ready, 1'b1);

    // Reset in the middle of a cache0 evict burst.
    @(negedge clk);
    rdata_v = 1'b0;
    pkt_a[0] = mk(1'b1, 32'h4000, 2'd1); pkt_v = 2'b01; mem_pkt_yumi = 1'b1;
    #1;
    check("t6_wr_grant", pkt_yumi, 2'b01);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      pkt_a[0] = mk(1'b0, 32'h5000, 2'd0); pkt_v = 2'b11;
      ev_v = 2'b11; wdata_yumi = 1'b1; rdata_v = 1'b1; rtag = 3'b000;
      #1;
      check("t6_beat", ev_yumi, 2'b01);
    end
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_wdata_v", wdata_v, 1'b0);
    check("t6_rst_ev_yumi", ev_yumi, 2'b00);
    check("t6_rst_pkt_v", mem_pkt_v, 1'b0);
    check("t6_rst_pkt_yumi", pkt_yumi, 2'b00);
    check("t6_rst_rf_v", rf_v, 2'b00);
    @(negedge clk);
    rst = 1'b0; ev_v = 2'b00; wdata_yumi = 1'b0; rdata_v = 1'b0;
    #1;
    check("t6_ptr_zero", pkt_yumi, 2'b01);
    check("t6_idle", wdata_v, 1'b0);

    // Randomized traffic against the model.
    @(negedge clk);
    idle(); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        pkt_v[i]   = ($urandom_range(0, 2) != 0);
        pkt_a[i]   = mk($urandom_range(0, 3) == 0, $urandom, LGM'($urandom));
        ev_v[i]    = ($urandom_range(0, 3) != 0);
        ev_data[i] = rnd128();
      end
      rf_ready = N'($urandom); rdata_v = 1'($urandom); rtag = 3'($urandom); rdata = rnd128();
      mem_pkt_yumi = 1'b0; wdata_yumi = 1'b0;
      #1;
      mem_pkt_yumi = mem_pkt_v & ($urandom_range(0, 3) != 0);
      wdata_yumi   = wdata_v & ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    chk_en = 1'b0;
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
